ps2_frame_rx: RTL and testbench

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx.sv | 144 ++++++++++++++
 tb/tb_ps2_frame_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 lines,
// decodes 11-bit frames, folds E0/F0 prefixes into flags and reports scan codes or errors.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] oCode,
  output logic       oBreak,
  output logic       oExt,
  output logic       oCodeRdy,
  output logic       oErr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_clkSync;
  logic [1:0]    r_dataSync;
  logic [FW-1:0] r_filtCnt;
  logic          r_filtClk;
  logic          r_filtClkD;
  logic [1:0]    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitCnt;
  logic          r_parity;
  logic          r_brkFlag;
  logic          r_extFlag;
  logic [TW-1:0] r_toCnt;

  logic w_clkS;
  logic w_data;
  logic w_sample;
  logic w_parOk;

  assign w_clkS   = r_clkSync[1];
  assign w_data   = r_dataSync[1];
  assign w_sample = r_filtClkD & ~r_filtClk;
  assign w_parOk  = ^{r_shift, r_parity};

  // Both lines idle high, so synchronizers and filter come out of reset at 1.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_filtCnt  <= '0;
      r_filtClk  <= 1'b1;
      r_filtClkD <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], PS2_CLK};
      r_dataSync <= {r_dataSync[0], PS2_DATA};
      r_filtClkD <= r_filtClk;
      if (w_clkS == r_filtClk) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FILT_LAST) begin
        r_filtClk <= w_clkS;
        r_filtCnt <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  // A sample event always beats a timeout landing in the same cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_parity  <= 1'b0;
      r_brkFlag <= 1'b0;
      r_extFlag <= 1'b0;
      r_toCnt   <= '0;
      oCode     <= '0;
      oBreak    <= 1'b0;
      oExt      <= 1'b0;
      oCodeRdy  <= 1'b0;
      oErr      <= 1'b0;
    end else begin
      oCodeRdy <= 1'b0;
      oErr     <= 1'b0;
      if (r_state == S_IDLE || w_sample) r_toCnt <= '0;
      else                               r_toCnt <= r_toCnt + 1'b1;

      if (w_sample) begin
        case (r_state)
          S_IDLE: begin
            if (!w_data) begin
              r_state  <= S_DATA;
              r_bitCnt <= '0;
            end
          end
          S_DATA: begin
            r_shift  <= {w_data, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= w_data;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (w_data && w_parOk) begin
              if (r_shift == 8'hE0) begin
                r_extFlag <= 1'b1;
              end else if (r_shift == 8'hF0) begin
                r_brkFlag <= 1'b1;
              end else begin
                oCode     <= r_shift;
                oBreak    <= r_brkFlag;
                oExt      <= r_extFlag;
                oCodeRdy  <= 1'b1;
                r_brkFlag <= 1'b0;
                r_extFlag <= 1'b0;
              end
            end else begin
              oErr      <= 1'b1;
              r_brkFlag <= 1'b0;
              r_extFlag <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE && r_toCnt == TO_LAST) begin
        oErr      <= 1'b1;
        r_state   <= S_IDLE;
        r_brkFlag <= 1'b0;
        r_extFlag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: directed and randomized PS/2 frames compared against a
// byte-level decoder model that tracks prefix flags and expected pulse counts.
module tb_ps2_frame_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 300;
  localparam int HALF_BIT   = 15;

  logic       CLK;
  logic       reset;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] oCode;
  logic       oBreak;
  logic       oExt;
  logic       oCodeRdy;
  logic       oErr;

  int checkCount = 0;
  int errorCount = 0;
  int rdyPulses  = 0;
  int errPulses  = 0;
  int bothPulses = 0;

  // Model state: what the outputs should read and how many pulses are owed.
  logic [7:0] expCode;
  logic       expBreak;
  logic       expExt;
  logic       modelBrk;
  logic       modelExt;
  int         expRdy;
  int         expErr;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .oCode(oCode), .oBreak(oBreak), .oExt(oExt), .oCodeRdy(oCodeRdy), .oErr(oErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse monitor counts high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge CLK) begin
    if (reset) begin
      if (oCodeRdy) rdyPulses++;
      if (oErr) errPulses++;
      if (oCodeRdy && oErr) bothPulses++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic sendBit(input logic b);
    PS2_DATA = b;
    waitCycles(HALF_BIT / 2);
    PS2_CLK = 1'b0;
    waitCycles(HALF_BIT);
    PS2_CLK = 1'b1;
    waitCycles(HALF_BIT - HALF_BIT / 2);
  endtask

  task automatic modelFrame(input logic [7:0] code, input logic ok);
    if (!ok) begin
      expErr++;
      modelBrk = 1'b0;
      modelExt = 1'b0;
    end else if (code == 8'hE0) begin
      modelExt = 1'b1;
    end else if (code == 8'hF0) begin
      modelBrk = 1'b1;
    end else begin
      expCode  = code;
      expBreak = modelBrk;
      expExt   = modelExt;
      expRdy++;
      modelBrk = 1'b0;
      modelExt = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic badParity, input logic stopBit);
    logic [10:0] frame;
    logic        par;
    par   = ~(^code) ^ badParity;
    frame = {stopBit, par, code, 1'b0};
    for (int i = 0; i < 11; i++) sendBit(frame[i]);
    PS2_DATA = 1'b1;
    waitCycles(20);
    modelFrame(code, !badParity && stopBit);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".rdy"}, rdyPulses, expRdy);
    checkOutput({tag, ".err"}, errPulses, expErr);
    checkOutput({tag, ".code"}, oCode, expCode);
    checkOutput({tag, ".brk"}, oBreak, expBreak);
    checkOutput({tag, ".ext"}, oExt, expExt);
  endtask

  task automatic doReset();
    reset = 1'b0;
    waitCycles(5);
    expCode  = 8'h00;
    expBreak = 1'b0;
    expExt   = 1'b0;
    modelBrk = 1'b0;
    modelExt = 1'b0;
    reset = 1'b1;
    waitCycles(5);
  endtask

  initial begin
    logic [7:0] rc;
    logic       rb;
    logic       rs;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    expRdy = 0;
    expErr = 0;
    doReset();
    checkState("reset");
    checkOutput("reset.rdyLow", oCodeRdy, 1'b0);
    checkOutput("reset.errLow", oErr, 1'b0);

    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkState("make1C");

    applyStimulus(8'hF0, 1'b0, 1'b1);
    checkState("prefixF0");
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkState("break1C");

    applyStimulus(8'hE0, 1'b0, 1'b1);
    applyStimulus(8'hF0, 1'b0, 1'b1);
    applyStimulus(8'h75, 1'b0, 1'b1);
    checkState("extBreak75");
    applyStimulus(8'h75, 1'b0, 1'b1);
    checkState("plain75");

    applyStimulus(8'h1C, 1'b1, 1'b1);
    checkState("badParity");
    applyStimulus(8'h33, 1'b0, 1'b0);
    checkState("badStop");

    // Prefix followed by a frame that stalls after five data bits.
    applyStimulus(8'hE0, 1'b0, 1'b1);
    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    PS2_DATA = 1'b1;
    waitCycles(TIMEOUT + 50);
    modelFrame(8'h00, 1'b0);
    checkState("timeout");
    applyStimulus(8'h16, 1'b0, 1'b1);
    checkState("after16");

    // Two-cycle low glitch with data low: if it leaked through it would start a frame and time out.
    PS2_DATA = 1'b0;
    PS2_CLK  = 1'b0;
    waitCycles(2);
    PS2_CLK  = 1'b1;
    waitCycles(3);
    PS2_DATA = 1'b1;
    waitCycles(TIMEOUT + 50);
    checkState("glitch");

    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(i[0]);
    doReset();
    checkState("midReset");
    applyStimulus(8'h29, 1'b0, 1'b1);
    checkState("after29");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       rc = 8'hE0;
        1:       rc = 8'hF0;
        default: rc = 8'($urandom);
      endcase
      rb = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 9) != 0);
      applyStimulus(rc, rb, rs);
      checkState($sformatf("rand%0d", n));
    end

    checkOutput("neverBoth", bothPulses, 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
